keypad_entry: RTL and testbench

Operand-entry controller directly downstream of the 4x4 keypad scanner. It consumes one decoded key code per press and assembles two BCD operands and an operator. On '#' it hands the operands and operator to the arithmetic stage over a req/ack handshake. While an operand is being typed, the entry in progress drives the 7-segment display path.

---
 rtl/calc_pkg.sv | 50 +++++
 rtl/bcd_entry_reg.sv | 61 ++++++
 rtl/keypad_entry.sv | 146 ++++++++++++++
 tb/tb_keypad_entry.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared key codes, operator and entry-state types for keypad entry
// Ports: none (package).
package calc_pkg;

    localparam logic [3:0] KEY_0    = 4'd0;
    localparam logic [3:0] KEY_1    = 4'd1;
    localparam logic [3:0] KEY_2    = 4'd2;
    localparam logic [3:0] KEY_3    = 4'd3;
    localparam logic [3:0] KEY_4    = 4'd4;
    localparam logic [3:0] KEY_5    = 4'd5;
    localparam logic [3:0] KEY_6    = 4'd6;
    localparam logic [3:0] KEY_7    = 4'd7;
    localparam logic [3:0] KEY_8    = 4'd8;
    localparam logic [3:0] KEY_9    = 4'd9;
    localparam logic [3:0] KEY_A    = 4'd10;
    localparam logic [3:0] KEY_B    = 4'd11;
    localparam logic [3:0] KEY_C    = 4'd12;
    localparam logic [3:0] KEY_D    = 4'd13;
    localparam logic [3:0] KEY_HASH = 4'd14;
    localparam logic [3:0] KEY_STAR = 4'd15;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        ISSUE   = 2'd2
    } entry_state_t;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= KEY_9;
    endfunction

    function automatic logic is_op_key(input logic [3:0] code);
        return (code >= KEY_A) && (code <= KEY_D);
    endfunction

    // Operator keys A..D are consecutive codes, so the offset from KEY_A is the op.
    function automatic op_t key_to_op(input logic [3:0] code);
        logic [3:0] offs;
        offs = code - KEY_A;
        return op_t'(offs[1:0]);
    endfunction

endpackage

// File: rtl/bcd_entry_reg.sv
// rtl/bcd_entry_reg.sv - BCD shift-in entry register with digit count and full flag
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   clr             clear value and count (wins over shift_en)
//   shift_en        shift value left one nibble and insert digit (ignored when full)
//   digit           BCD digit to insert into nibble 0
//   value           assembled BCD value, nibble 0 least significant
//   count           number of digits entered so far
//   full            count has reached DIGITS
module bcd_entry_reg #(
    parameter int DIGITS = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         shift_en,
    input  logic [3:0]                   digit,
    output logic [4*DIGITS-1:0]          value,
    output logic [$clog2(DIGITS+1)-1:0]  count,
    output logic                         full
);
    import calc_pkg::*;

    localparam int CNT_W = $clog2(DIGITS+1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIGITS);

    logic [4*DIGITS-1:0] value_q, value_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [4*DIGITS+3:0] shifted;

    // Appending the digit then keeping the low nibbles drops the old top digit.
    assign shifted = {value_q, digit};
    assign full    = (count_q == CNT_MAX);

    always_comb begin
        value_d = value_q;
        count_d = count_q;
        if (clr) begin
            value_d = '0;
            count_d = '0;
        end else if (shift_en && !full) begin
            value_d = shifted[4*DIGITS-1:0];
            count_d = count_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
            count_q <= '0;
        end else begin
            value_q <= value_d;
            count_q <= count_d;
        end
    end

    assign value = value_q;
    assign count = count_q;

endmodule

// File: rtl/keypad_entry.sv
// rtl/keypad_entry.sv - keypad operand/operator entry with req/ack issue to arithmetic stage
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   key_code, key_valid  decoded key and its one-cycle strobe
//   calc_ack             arithmetic stage accepts the pending transaction
//   calc_req             transaction pending
//   operand_a/operand_b  BCD operands, nibble 0 least significant
//   op                   operator (add/sub/mul/div)
//   disp_bcd, disp_sel   entry being shown and which operand it is
//   digit_cnt            digits in the entry being shown
module keypad_entry #(
    parameter int DIGITS = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [3:0]                   key_code,
    input  logic                         key_valid,
    input  logic                         calc_ack,
    output logic                         calc_req,
    output logic [4*DIGITS-1:0]          operand_a,
    output logic [4*DIGITS-1:0]          operand_b,
    output logic [1:0]                   op,
    output logic [4*DIGITS-1:0]          disp_bcd,
    output logic                         disp_sel,
    output logic [$clog2(DIGITS+1)-1:0]  digit_cnt
);
    import calc_pkg::*;

    localparam int CNT_W = $clog2(DIGITS+1);

    entry_state_t state_q, state_d;
    op_t          op_q, op_d;
    logic         calc_req_q, calc_req_d;

    logic a_clr, a_shift, b_clr, b_shift;
    logic [4*DIGITS-1:0] a_value, b_value;
    logic [CNT_W-1:0]    a_count, b_count;
    logic                a_full, b_full;

    bcd_entry_reg #(.DIGITS(DIGITS)) u_reg_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (a_clr),
        .shift_en (a_shift),
        .digit    (key_code),
        .value    (a_value),
        .count    (a_count),
        .full     (a_full)
    );

    bcd_entry_reg #(.DIGITS(DIGITS)) u_reg_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (b_clr),
        .shift_en (b_shift),
        .digit    (key_code),
        .value    (b_value),
        .count    (b_count),
        .full     (b_full)
    );

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        calc_req_d = calc_req_q;
        a_clr      = 1'b0;
        a_shift    = 1'b0;
        b_clr      = 1'b0;
        b_shift    = 1'b0;

        case (state_q)
            ENTER_A: begin
                if (key_valid) begin
                    if (is_digit(key_code)) begin
                        a_shift = 1'b1;
                    end else if (is_op_key(key_code)) begin
                        op_d    = key_to_op(key_code);
                        b_clr   = 1'b1;
                        state_d = ENTER_B;
                    end else if (key_code == KEY_STAR) begin
                        a_clr = 1'b1;
                        b_clr = 1'b1;
                        op_d  = OP_ADD;
                    end
                end
            end
            ENTER_B: begin
                if (key_valid) begin
                    if (is_digit(key_code)) begin
                        b_shift = 1'b1;
                    end else if (is_op_key(key_code)) begin
                        op_d = key_to_op(key_code);
                    end else if (key_code == KEY_HASH) begin
                        calc_req_d = 1'b1;
                        state_d    = ISSUE;
                    end else begin
                        a_clr   = 1'b1;
                        b_clr   = 1'b1;
                        op_d    = OP_ADD;
                        state_d = ENTER_A;
                    end
                end
            end
            ISSUE: begin
                // Keys are never decoded here, so a key coinciding with the ack is dropped.
                if (calc_req_q && calc_ack) begin
                    calc_req_d = 1'b0;
                    a_clr      = 1'b1;
                    b_clr      = 1'b1;
                    op_d       = OP_ADD;
                    state_d    = ENTER_A;
                end
            end
            default: begin
                calc_req_d = 1'b0;
                a_clr      = 1'b1;
                b_clr      = 1'b1;
                op_d       = OP_ADD;
                state_d    = ENTER_A;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ENTER_A;
            op_q       <= OP_ADD;
            calc_req_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            calc_req_q <= calc_req_d;
        end
    end

    // Display muxing selects only between flops on a registered state, so no
    // input reaches an output combinationally.
    assign calc_req  = calc_req_q;
    assign operand_a = a_value;
    assign operand_b = b_value;
    assign op        = op_q;
    assign disp_sel  = (state_q != ENTER_A);
    assign disp_bcd  = (state_q == ENTER_A) ? a_value : b_value;
    assign digit_cnt = (state_q == ENTER_A) ? a_count : b_count;

endmodule

// File: tb/tb_keypad_entry.sv
// tb/tb_keypad_entry.sv - directed self-checking bench for keypad_entry
module tb_keypad_entry;

    logic        clk;
    logic        rst_n;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        calc_ack;
    logic        calc_req;
    logic [15:0] operand_a;
    logic [15:0] operand_b;
    logic [1:0]  op;
    logic [15:0] disp_bcd;
    logic        disp_sel;
    logic [2:0]  digit_cnt;

    int checks;
    int failures;

    keypad_entry #(.DIGITS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .calc_ack  (calc_ack),
        .calc_req  (calc_req),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .op        (op),
        .disp_bcd  (disp_bcd),
        .disp_sel  (disp_sel),
        .digit_cnt (digit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive on the falling edge; the following rising edge samples the key and
    // the next falling edge is where results are observed.
    task automatic press(input logic [3:0] k);
        @(negedge clk);
        key_code  = k;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        key_code  = 4'd0;
        key_valid = 1'b0;
        calc_ack  = 1'b0;
        idle(3);

        check("rst_req",  calc_req,  0);
        check("rst_a",    operand_a, 0);
        check("rst_b",    operand_b, 0);
        check("rst_op",   op,        0);
        check("rst_disp", disp_bcd,  0);
        check("rst_sel",  disp_sel,  0);
        check("rst_cnt",  digit_cnt, 0);
        rst_n = 1'b1;
        idle(1);

        // 1,2,3 A 4,5 #
        press(4'd1); press(4'd2); press(4'd3);
        check("t1_disp_a", disp_bcd, 16'h0123);
        check("t1_cnt_a",  digit_cnt, 3);
        press(4'd10);
        check("t1_sel_b",  disp_sel, 1);
        check("t1_cnt_b0", digit_cnt, 0);
        check("t1_a_frz",  operand_a, 16'h0123);
        press(4'd4); press(4'd5);
        check("t1_b",      operand_b, 16'h0045);
        check("t1_disp_b", disp_bcd, 16'h0045);
        check("t1_req_pre", calc_req, 0);
        press(4'd14);
        check("t1_req",    calc_req, 1);
        check("t1_a",      operand_a, 16'h0123);
        check("t1_b2",     operand_b, 16'h0045);
        check("t1_op",     op, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_req", calc_req, 1);
            check("hold_a",   operand_a, 16'h0123);
            check("hold_b",   operand_b, 16'h0045);
            check("hold_op",  op, 0);
        end
        calc_ack = 1'b1;
        @(negedge clk);
        calc_ack = 1'b0;
        check("ack_req",  calc_req, 0);
        check("ack_a",    operand_a, 0);
        check("ack_b",    operand_b, 0);
        check("ack_sel",  disp_sel, 0);
        check("ack_cnt",  digit_cnt, 0);

        // Ack with no request pending is ignored
        press(4'd1);
        @(negedge clk);
        calc_ack = 1'b1;
        @(negedge clk);
        calc_ack = 1'b0;
        check("stray_ack_a",   operand_a, 16'h0001);
        check("stray_ack_req", calc_req, 0);
        press(4'd15);
        check("star_a_clr", operand_a, 0);

        // Overflow: fifth digit ignored
        press(4'd9); press(4'd8); press(4'd7); press(4'd6);
        check("full_a",   operand_a, 16'h9876);
        check("full_cnt", digit_cnt, 4);
        press(4'd5);
        check("ovf_a",    operand_a, 16'h9876);
        check("ovf_cnt",  digit_cnt, 4);
        press(4'd12);
        check("op_c",     op, 2);
        press(4'd13);
        check("op_d",     op, 3);
        check("op_d_sel", disp_sel, 1);
        // '#' with ack already high: req for exactly one cycle
        @(negedge clk);
        key_code  = 4'd14;
        key_valid = 1'b1;
        calc_ack  = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        check("t2_req",   calc_req, 1);
        check("t2_op",    op, 3);
        check("t2_b",     operand_b, 0);
        check("t2_a",     operand_a, 16'h9876);
        @(negedge clk);
        calc_ack = 1'b0;
        check("t2_req_drop", calc_req, 0);
        check("t2_op_clr",   op, 0);

        // '#' in ENTER_A ignored; '*' in ENTER_B clears all
        press(4'd2);
        press(4'd14);
        check("hash_a_req", calc_req, 0);
        check("hash_a_sel", disp_sel, 0);
        check("hash_a_val", operand_a, 16'h0002);
        press(4'd15);
        press(4'd1); press(4'd2); press(4'd11);
        check("t3_op",  op, 1);
        check("t3_sel", disp_sel, 1);
        check("t3_a",   operand_a, 16'h0012);
        press(4'd15);
        check("t3_clr_a",   operand_a, 0);
        check("t3_clr_op",  op, 0);
        check("t3_clr_sel", disp_sel, 0);
        check("t3_clr_cnt", digit_cnt, 0);

        // Keys during ISSUE are ignored, including on the ack cycle
        press(4'd3); press(4'd10); press(4'd6); press(4'd14);
        check("t4_req", calc_req, 1);
        press(4'd15);
        press(4'd7);
        check("t4_req_hold", calc_req, 1);
        check("t4_a",        operand_a, 16'h0003);
        check("t4_b",        operand_b, 16'h0006);
        check("t4_disp",     disp_bcd, 16'h0006);
        check("t4_op",       op, 0);
        @(negedge clk);
        key_code  = 4'd9;
        key_valid = 1'b1;
        calc_ack  = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        calc_ack  = 1'b0;
        check("t4_req_drop", calc_req, 0);
        check("t4_a_clr",    operand_a, 0);
        check("t4_b_clr",    operand_b, 0);
        check("t4_cnt",      digit_cnt, 0);
        check("t4_sel",      disp_sel, 0);

        // Asynchronous reset mid-ISSUE
        press(4'd4); press(4'd11); press(4'd8); press(4'd14);
        check("t5_req", calc_req, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_req", calc_req, 0);
        check("t5_rst_a",   operand_a, 0);
        check("t5_rst_b",   operand_b, 0);
        check("t5_rst_op",  op, 0);
        check("t5_rst_sel", disp_sel, 0);
        @(negedge clk);
        rst_n = 1'b1;
        press(4'd5);
        check("t5_a",   operand_a, 16'h0005);
        check("t5_cnt", digit_cnt, 1);
        check("t5_req_idle", calc_req, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
